montgomery_exp_ctrl: RTL and testbench

//  Initiator side of the montgomery_mul handshake. Computes result = base^exponent mod m

---
 rtl/montgomery_exp_ctrl_pkg.sv | 27 ++
 rtl/montgomery_exp_ctrl.sv | 149 ++++++++++++++
 tb/tb_montgomery_exp_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_exp_ctrl_pkg.sv
// Shared definitions for montgomery_exp_ctrl.
//  op_e    : which modexp step the controller is in (one multiplier request per step)
//  phase_e : ISSUE (request pulse cycle) / WAIT (waiting for the multiplier's done pulse)
//  is_mult : true for steps that issue a multiplier request
package montgomery_exp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TO_X,    // xb  = mont(base, R^2)
      ST_TO_ONE,  // acc = mont(1, R^2) = R mod m
      ST_SQR,     // acc = mont(acc, acc)
      ST_MUL,     // acc = mont(acc, xb)
      ST_FROM,    // res = mont(acc, 1)
      ST_DONE
   } op_e;

   typedef enum logic {
      PH_ISSUE,
      PH_WAIT
   } phase_e;

   function automatic logic is_mult(input op_e s);
      return (s == ST_TO_X) || (s == ST_TO_ONE) || (s == ST_SQR) ||
             (s == ST_MUL)  || (s == ST_FROM);
   endfunction

endpackage

// File: rtl/montgomery_exp_ctrl.sv
// montgomery_exp_ctrl: left-to-right square-and-multiply modular exponentiation,
// driving one external Montgomery multiplier through an enable/done handshake.
// Ports:
//  clk, rst_n                     clock, asynchronous active-low reset
//  enable_p                       1-cycle start pulse (ignored unless idle)
//  base, exponent, m, m_size,     operands, latched on accepted start
//  r2_mod
//  busy                           high while an operation is in flight
//  result, done_irq_p             base^exponent mod m, updated with a 1-cycle pulse
//  mul_enable_p                   1-cycle request to the multiplier
//  mul_a, mul_b, mul_m,           multiplier operands, stable from request to done
//  mul_m_size
//  mul_y, mul_done_irq_p          multiplier result and completion pulse
module montgomery_exp_ctrl
   import montgomery_exp_ctrl_pkg::*;
#(
   parameter int NBITS = 2048,
   parameter int EBITS = 2048
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable_p,
   input  logic [NBITS-1:0]         base,
   input  logic [EBITS-1:0]         exponent,
   input  logic [NBITS-1:0]         m,
   input  logic [$clog2(NBITS):0]   m_size,
   input  logic [NBITS-1:0]         r2_mod,
   output logic                     busy,
   output logic [NBITS-1:0]         result,
   output logic                     done_irq_p,
   output logic                     mul_enable_p,
   output logic [NBITS-1:0]         mul_a,
   output logic [NBITS-1:0]         mul_b,
   output logic [NBITS-1:0]         mul_m,
   output logic [$clog2(NBITS):0]   mul_m_size,
   input  logic [NBITS-1:0]         mul_y,
   input  logic                     mul_done_irq_p
);

   localparam int IW = $clog2(EBITS) + 1;
   localparam int XW = (EBITS > 1) ? $clog2(EBITS) : 1;
   localparam logic [NBITS-1:0] MONT_ONE = NBITS'(1);
   localparam logic [IW-1:0]    TOP_BIT  = IW'(EBITS - 1);

   op_e    op, op_n;
   phase_e ph, ph_n;

   logic [NBITS-1:0]       base_q, m_q, r2_q, xb, acc;
   logic [EBITS-1:0]       exp_q;
   logic [$clog2(NBITS):0] msize_q;
   logic [IW-1:0]          bit_idx;
   logic                   exp_bit, last_bit, mul_done, start;

   assign exp_bit  = exp_q[bit_idx[XW-1:0]];
   assign last_bit = (bit_idx == '0);
   // Completion only counts while this block is actually waiting on a request.
   assign mul_done = (ph == PH_WAIT) && mul_done_irq_p && is_mult(op);
   assign start    = (op == ST_IDLE) && enable_p;

   assign mul_m      = m_q;
   assign mul_m_size = msize_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op <= ST_IDLE;
         ph <= PH_ISSUE;
      end else begin
         op <= op_n;
         ph <= ph_n;
      end
   end

   always_comb begin
      op_n         = op;
      ph_n         = ph;
      mul_enable_p = 1'b0;
      mul_a        = '0;
      mul_b        = '0;
      busy         = (op != ST_IDLE) && (op != ST_DONE);
      done_irq_p   = (op == ST_DONE);

      // Operands come only from latched registers, so they hold through WAIT.
      case (op)
         ST_TO_X:   begin mul_a = base_q;   mul_b = r2_q;     end
         ST_TO_ONE: begin mul_a = MONT_ONE; mul_b = r2_q;     end
         ST_SQR:    begin mul_a = acc;      mul_b = acc;      end
         ST_MUL:    begin mul_a = acc;      mul_b = xb;       end
         ST_FROM:   begin mul_a = acc;      mul_b = MONT_ONE; end
         default:   ;
      endcase

      case (op)
         ST_IDLE: if (enable_p) begin
            op_n = ST_TO_X;
            ph_n = PH_ISSUE;
         end
         ST_DONE: op_n = ST_IDLE;
         default: begin
            if (ph == PH_ISSUE) begin
               mul_enable_p = 1'b1;
               ph_n         = PH_WAIT;
            end else if (mul_done) begin
               ph_n = PH_ISSUE;
               case (op)
                  ST_TO_X:   op_n = ST_TO_ONE;
                  ST_TO_ONE: op_n = ST_SQR;
                  ST_SQR:    op_n = exp_bit ? ST_MUL : (last_bit ? ST_FROM : ST_SQR);
                  ST_MUL:    op_n = last_bit ? ST_FROM : ST_SQR;
                  default:   op_n = ST_DONE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= '0;
         exp_q   <= '0;
         m_q     <= '0;
         msize_q <= '0;
         r2_q    <= '0;
         xb      <= '0;
         acc     <= '0;
         bit_idx <= '0;
         result  <= '0;
      end else begin
         if (start) begin
            base_q  <= base;
            exp_q   <= exponent;
            m_q     <= m;
            msize_q <= m_size;
            r2_q    <= r2_mod;
            bit_idx <= TOP_BIT;
         end
         if (mul_done) begin
            case (op)
               ST_TO_X: xb <= mul_y;
               ST_FROM: result <= mul_y;
               default: acc <= mul_y;
            endcase
            // Bit index steps down once the bit is fully handled; it stops at 0.
            if (!last_bit && ((op == ST_MUL) || ((op == ST_SQR) && !exp_bit)))
               bit_idx <= bit_idx - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
module tb_montgomery_exp_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_p = 1'b0;
   logic [15:0] base = '0, m = '0, r2_mod = '0;
   logic [7:0]  exponent = '0;
   logic [4:0]  m_size = '0;
   logic        busy, done_irq_p, mul_enable_p;
   logic [15:0] result, mul_a, mul_b, mul_m, mul_y;
   logic [4:0]  mul_m_size;
   logic        mul_done_irq_p = 1'b0;

   int errors = 0;
   int checks = 0;

   montgomery_exp_ctrl #(.NBITS(16), .EBITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable_p(enable_p), .base(base), .exponent(exponent),
      .m(m), .m_size(m_size), .r2_mod(r2_mod), .busy(busy), .result(result),
      .done_irq_p(done_irq_p), .mul_enable_p(mul_enable_p), .mul_a(mul_a), .mul_b(mul_b),
      .mul_m(mul_m), .mul_m_size(mul_m_size), .mul_y(mul_y), .mul_done_irq_p(mul_done_irq_p)
   );

   always #5 clk = ~clk;

   // ---------------- reference arithmetic (R = 2^16) ----------------
   function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] mm);
      longint t = longint'(a) * longint'(b);
      for (int k = 0; k < 16; k++) begin
         if (t[0]) t = t + longint'(mm);
         t = t >> 1;
      end
      if (t >= longint'(mm)) t = t - longint'(mm);
      return t[15:0];
   endfunction

   function automatic logic [15:0] modexp(input logic [15:0] b, input logic [7:0] e,
                                          input logic [15:0] mm);
      longint r = 1 % longint'(mm);
      for (int k = 7; k >= 0; k--) begin
         r = (r * r) % longint'(mm);
         if (e[k]) r = (r * longint'(b)) % longint'(mm);
      end
      return r[15:0];
   endfunction

   function automatic logic [15:0] r2_of(input logic [15:0] mm);
      longint rm = (longint'(1) << 16) % longint'(mm);
      longint v  = (rm * rm) % longint'(mm);
      return v[15:0];
   endfunction

   // ---------------- multiplier model + protocol monitor ----------------
   int          req_cnt = 0, done_cnt = 0, proto_err = 0;
   logic        stray_req = 1'b0;
   logic        pending = 1'b0;
   int          lat_left = 0;
   logic [15:0] ca, cb, cm;
   logic [4:0]  cs;

   always @(negedge clk) begin
      if (done_irq_p) done_cnt++;
      if (!rst_n) begin
         pending = 1'b0;
         mul_done_irq_p = 1'b0;
      end else begin
         mul_done_irq_p = 1'b0;
         if (mul_enable_p) req_cnt++;
         if (stray_req) begin
            mul_done_irq_p = 1'b1;
            mul_y = 16'h5A5A;
         end else if (pending) begin
            if (mul_enable_p || mul_a !== ca || mul_b !== cb || mul_m !== cm ||
                mul_m_size !== cs) proto_err++;
            if (lat_left <= 1) begin
               mul_done_irq_p = 1'b1;
               mul_y = mont(ca, cb, cm);
               pending = 1'b0;
            end else lat_left--;
         end else if (mul_enable_p) begin
            ca = mul_a; cb = mul_b; cm = mul_m; cs = mul_m_size;
            pending = 1'b1;
            lat_left = $urandom_range(1, 5);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts an operation at a negedge, waits for done, checks result/request count.
   // disturb_at>0 pulses enable_p with other operands mid-run; poke pulses it in DONE.
   task automatic run_op(input logic [15:0] b, input logic [7:0] e, input logic [15:0] mm,
                         input int disturb_at, input bit poke, input string tag);
      int req0, done0, cyc;
      bit got;
      logic [15:0] want;
      want = modexp(b, e, mm);
      req0 = req_cnt; done0 = done_cnt;
      base = b; exponent = e; m = mm; r2_mod = r2_of(mm); m_size = 5'd16;
      enable_p = 1'b1;
      @(negedge clk);
      enable_p = 1'b0;
      chk({tag, "_busy_rise"}, busy, 1);
      got = 0; cyc = 0;
      while (!got && cyc < 3000) begin
         if (done_irq_p) got = 1;
         else begin
            if (disturb_at != 0 && cyc == disturb_at) begin
               base = 16'd5; exponent = 8'h3C; m = 16'd7; r2_mod = r2_of(16'd7);
               enable_p = 1'b1;
            end else enable_p = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      enable_p = 1'b0;
      chk({tag, "_done_seen"}, got, 1);
      if (got) begin
         chk({tag, "_result"}, result, want);
         chk({tag, "_busy_at_done"}, busy, 0);
         chk({tag, "_requests"}, req_cnt - req0, 3 + 8 + $countones(e));
         if (poke) enable_p = 1'b1;
         @(negedge clk);
         enable_p = 1'b0;
         chk({tag, "_done_pulse"}, done_irq_p, 0);
         chk({tag, "_busy_after"}, busy, 0);
         chk({tag, "_result_held"}, result, want);
         chk({tag, "_done_count"}, done_cnt - done0, 1);
      end
   endtask

   initial begin
      int req0, cyc;
      logic [15:0] rm, rb;
      logic [7:0]  re;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_irq_p, 0);
      chk("rst_result", result, 0);
      chk("rst_mul_en", mul_enable_p, 0);
      chk("rst_mul_ab", {mul_a, mul_b}, 0);
      chk("rst_mul_m", {mul_m, 11'd0, mul_m_size}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'd3, 8'd5,    16'd13, 0, 0, "b3e5");
      run_op(16'd2, 8'hFF,   16'd11, 0, 0, "b2eff");
      run_op(16'd7, 8'd0,    16'd13, 0, 0, "exp0");
      run_op(16'd0, 8'd7,    16'd13, 0, 0, "base0");
      run_op(16'd6, 8'hA7,   16'd13, 9, 0, "disturb");
      run_op(16'd4, 8'h81,   16'd29, 0, 1, "done_poke");

      // Abort during the WAIT of the 5th request.
      req0 = req_cnt;
      base = 16'd3; exponent = 8'hA5; m = 16'd13; r2_mod = r2_of(16'd13); m_size = 5'd16;
      enable_p = 1'b1;
      @(negedge clk);
      enable_p = 1'b0;
      cyc = 0;
      while (!((req_cnt - req0) >= 5 && !mul_enable_p) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_reached", ((req_cnt - req0) >= 5) ? 1 : 0, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_mul_en", mul_enable_p, 0);
      chk("abort_result", result, 0);
      chk("abort_mul_ops", {mul_a, mul_m}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req0 = req_cnt;
      @(posedge clk); #1 stray_req = 1'b1;
      @(posedge clk); #1 stray_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_result", result, 0);
      chk("stray_no_req", req_cnt - req0, 0);
      run_op(16'd10, 8'hC3, 16'd13, 0, 0, "post_abort");

      // Back-to-back random operations.
      for (int n = 0; n < 50; n++) begin
         rm = 16'($urandom_range(1, 32767) * 2 + 1);
         rb = 16'($urandom_range(0, int'(rm) - 1));
         re = 8'($urandom);
         run_op(rb, re, rm, 0, 0, "rand");
      end

      chk("protocol", proto_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
